// File: rtl/apb_master_bridge.sv
// CPU-to-APB master bridge: turns single-cycle load/store pulses into APB SETUP/ACCESS
// transfers, with a wait-state watchdog that aborts transfers that are never readied.
module apb_master_bridge #(
  parameter int APB_ADDR_W = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [APB_ADDR_W-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic                  cpu_busy,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  output logic [31:0]           cpu_rdata,
  output logic [APB_ADDR_W-1:0] paddr,
  output logic                  psel_cpu,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           pwdata,
  input  logic [31:0]           prdata_cpu,
  input  logic                  pready_cpu
);

  // Keep a 1-bit counter when the watchdog is disabled so the width never collapses to 0.
  localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    busy_q, busy_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [APB_ADDR_W-1:0]   paddr_q, paddr_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic                    timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == TIMEOUT_CNT);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          paddr_d   = cpu_addr;
          pwrite_d  = cpu_we;
          pwdata_d  = cpu_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          wcnt_d    = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A ready in the timeout cycle wins over the abort.
        if (pready_cpu) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = 1'b1;
          rdata_d   = pwrite_q ? 32'd0 : prdata_cpu;
          state_d   = ST_IDLE;
        end else if (timeout_hit) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = 1'b1;
          err_d     = 1'b1;
          rdata_d   = 32'd0;
          state_d   = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'd0;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign cpu_busy  = busy_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign paddr     = paddr_q;
  assign psel_cpu  = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed scenarios plus randomized transfers against a
// transaction-level model (ack cycle = req + 3 + min(waits, TIMEOUT), error when waits exceed it).
module tb_apb_master_bridge;

  localparam int AW = 16;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          prst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_busy;
  logic          cpu_ack;
  logic          cpu_err;
  logic [31:0]   cpu_rdata;
  logic [AW-1:0] paddr;
  logic          psel_cpu;
  logic          penable;
  logic          pwrite;
  logic [31:0]   pwdata;
  logic [31:0]   prdata_cpu;
  logic          pready_cpu;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(.APB_ADDR_W(AW), .TIMEOUT(TO)) dut (
    .pclk       (pclk),
    .prst       (prst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_busy   (cpu_busy),
    .cpu_ack    (cpu_ack),
    .cpu_err    (cpu_err),
    .cpu_rdata  (cpu_rdata),
    .paddr      (paddr),
    .psel_cpu   (psel_cpu),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata_cpu (prdata_cpu),
    .pready_cpu (pready_cpu)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(cpu_busy),  32'd0);
    check({tag, "_ack"},   32'(cpu_ack),   32'd0);
    check({tag, "_err"},   32'(cpu_err),   32'd0);
    check({tag, "_rdata"}, cpu_rdata,      32'd0);
    check({tag, "_paddr"}, 32'(paddr),     32'd0);
    check({tag, "_psel"},  32'(psel_cpu),  32'd0);
    check({tag, "_pen"},   32'(penable),   32'd0);
    check({tag, "_pwr"},   32'(pwrite),    32'd0);
    check({tag, "_pwd"},   pwdata,         32'd0);
  endtask

  // Called at a negedge: that cycle is the request cycle N. Returns at the negedge of the
  // expected ack cycle, after checking it, so a caller may chain the next request right there.
  task automatic xfer(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                      input int waits, input logic [31:0] rd, input logic poke);
    int kend;
    int cyc;
    logic exp_err;
    logic [31:0] exp_rd;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    pready_cpu = 1'b0;
    @(negedge pclk);
    check("setup_psel", 32'(psel_cpu), 32'd1);
    check("setup_pen",  32'(penable),  32'd0);
    check("setup_addr", 32'(paddr),    32'(addr));
    check("setup_pwr",  32'(pwrite),   32'(we));
    check("setup_pwd",  pwdata,        wdata);
    check("setup_busy", 32'(cpu_busy), 32'd1);
    check("setup_ack",  32'(cpu_ack),  32'd0);
    // A request while busy must be ignored; SETUP must not wait for ready either.
    cpu_req    = poke;
    cpu_we     = ~we;
    cpu_addr   = ~addr;
    cpu_wdata  = ~wdata;
    pready_cpu = 1'($urandom);
    prdata_cpu = $urandom;
    kend = (waits < TO) ? waits : TO;
    for (int k = 0; k <= kend; k++) begin
      @(negedge pclk);
      check("acc_psel", 32'(psel_cpu), 32'd1);
      check("acc_pen",  32'(penable),  32'd1);
      check("acc_addr", 32'(paddr),    32'(addr));
      check("acc_pwr",  32'(pwrite),   32'(we));
      check("acc_pwd",  pwdata,        wdata);
      check("acc_ack",  32'(cpu_ack),  32'd0);
      check("acc_err",  32'(cpu_err),  32'd0);
      check("acc_busy", 32'(cpu_busy), 32'd1);
      cpu_req    = poke & 1'($urandom);
      pready_cpu = (k == waits);
      prdata_cpu = (k == waits) ? rd : $urandom;
    end
    @(negedge pclk);
    cpu_req    = 1'b0;
    pready_cpu = 1'b0;
    exp_err = (waits > TO);
    exp_rd  = (exp_err || we) ? 32'd0 : rd;
    cyc = 3 + kend;
    check("done_ack",   32'(cpu_ack),  32'd1);
    check("done_err",   32'(cpu_err),  32'(exp_err));
    check("done_rdata", cpu_rdata,     exp_rd);
    check("done_psel",  32'(psel_cpu), 32'd0);
    check("done_pen",   32'(penable),  32'd0);
    check("done_busy",  32'(cpu_busy), 32'd0);
    check("done_addr",  32'(paddr),    32'(addr));
    check("done_pwr",   32'(pwrite),   32'(we));
    check("done_pwd",   pwdata,        wdata);
    $display("xfer we=%0d addr=%h wdata=%h waits=%0d poke=%0d -> ack at N+%0d err=%0d rdata=%h",
             we, addr, wdata, waits, poke, cyc, cpu_err, cpu_rdata);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      check("idle_ack",  32'(cpu_ack),  32'd0);
      check("idle_err",  32'(cpu_err),  32'd0);
      check("idle_busy", 32'(cpu_busy), 32'd0);
      check("idle_psel", 32'(psel_cpu), 32'd0);
      check("idle_pen",  32'(penable),  32'd0);
    end
  endtask

  initial begin
    prst       = 1'b1;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = 32'd0;
    prdata_cpu = 32'd0;
    pready_cpu = 1'b0;
    repeat (2) @(negedge pclk);
    check_all_zero("rst");
    prst = 1'b0;
    idle(1);

    // Reset in the middle of ACCESS: outputs clear, no ack appears afterwards.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 32'h0BAD_F00D;
    @(negedge pclk);
    cpu_req = 1'b0;
    @(negedge pclk);
    check("mid_pen", 32'(penable), 32'd1);
    prst = 1'b1;
    pready_cpu = 1'b1;
    @(negedge pclk);
    check_all_zero("midrst1");
    @(negedge pclk);
    check_all_zero("midrst2");
    prst = 1'b0;
    pready_cpu = 1'b0;
    idle(3);
    $display("reset mid-ACCESS done");

    xfer(1'b1, 16'h1804, 32'hA5A5_0001, 0, 32'h0, 1'b0);
    idle(1);
    xfer(1'b0, 16'h0808, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    xfer(1'b0, 16'h2000, 32'h0, 1000, 32'h0, 1'b0);
    idle(1);
    xfer(1'b1, 16'h0004, 32'h1111_2222, 1, 32'h0, 1'b1);
    xfer(1'b0, 16'h0010, 32'h0, TO, 32'hCAFE_0042, 1'b0);
    xfer(1'b0, 16'h0014, 32'h0, TO + 1, 32'h7777_7777, 1'b0);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      int w;
      w = (($urandom % 4) == 0) ? int'($urandom_range(TO - 1, TO + 3)) : int'($urandom_range(0, 5));
      xfer(1'($urandom), AW'($urandom), $urandom, w, $urandom, 1'($urandom));
      if (($urandom % 2) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
